// File: rtl/ctech_lib_clk_div_prog.sv
// Programmable multi-channel clock divider with glitch-free start, stop and ratio change.
// Latency: clkout rises 1 clk after en is sampled high; ratio updates apply at period boundaries.
// Backpressure: none; en is level-sensitive and a stop waits for the current period to finish.
module ctech_lib_clk_div_prog #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH*DIV_W-1:0]   div_ratio,
    output logic [NUM_CH-1:0]         clkout,
    output logic [NUM_CH-1:0]         div_active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [DIV_W-1:0] R_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

    state_e           state_q [NUM_CH];
    state_e           state_d [NUM_CH];
    logic [DIV_W-1:0] cnt_q   [NUM_CH];
    logic [DIV_W-1:0] cnt_d   [NUM_CH];
    logic [DIV_W-1:0] r_act_q [NUM_CH];
    logic [DIV_W-1:0] r_act_d [NUM_CH];
    logic [NUM_CH-1:0] clkout_q;
    logic [NUM_CH-1:0] clkout_d;

    // Ratios below 2 cannot produce both a high and a low phase, so they run as 2.
    function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
        return (r < R_MIN) ? R_MIN : r;
    endfunction

    // Number of high cycles per period: ceil(R/2), one bit wider to avoid overflow.
    function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] r);
        return ({1'b0, r} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    endfunction

    // Per-channel next state: idle/run control, period counter and registered clkout.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            r_act_d[i]  = r_act_q[i];
            clkout_d[i] = clkout_q[i];
            case (state_q[i])
                IDLE: begin
                    cnt_d[i]    = '0;
                    clkout_d[i] = 1'b0;
                    if (en[i]) begin
                        state_d[i]  = RUN;
                        r_act_d[i]  = clamp_ratio(div_ratio[i*DIV_W +: DIV_W]);
                        clkout_d[i] = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q[i] == r_act_q[i] - ONE) begin
                        // Boundary: clkout is already low here, so stopping or reloading is glitch-free.
                        cnt_d[i] = '0;
                        if (en[i]) begin
                            r_act_d[i]  = clamp_ratio(div_ratio[i*DIV_W +: DIV_W]);
                            clkout_d[i] = 1'b1;
                        end else begin
                            state_d[i]  = IDLE;
                            clkout_d[i] = 1'b0;
                        end
                    end else begin
                        cnt_d[i]    = cnt_q[i] + ONE;
                        clkout_d[i] = ({1'b0, cnt_d[i]} < high_len(r_act_q[i]));
                    end
                end
                default: begin
                    state_d[i]  = IDLE;
                    cnt_d[i]    = '0;
                    clkout_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Channel state registers; reset drops clkout immediately without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                r_act_q[i] <= R_MIN;
            end
            clkout_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                r_act_q[i] <= r_act_d[i];
            end
            clkout_q <= clkout_d;
        end
    end

    // Status mirrors the run state directly.
    always_comb begin
        div_active = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_active[i] = (state_q[i] == RUN);
        end
    end

    assign clkout = clkout_q;

endmodule

// File: tb/tb_ctech_lib_clk_div_prog.sv
module tb_ctech_lib_clk_div_prog;

    localparam int NCH = 4;
    localparam int DW  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     en;
    logic [NCH*DW-1:0]  div_ratio;
    logic [NCH-1:0]     clkout;
    logic [NCH-1:0]     div_active;

    int ratio_r [NCH];

    ctech_lib_clk_div_prog #(.NUM_CH(NCH), .DIV_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_ratio  (div_ratio),
        .clkout     (clkout),
        .div_active (div_active)
    );

    always #5 clk = ~clk;

    always_comb begin
        div_ratio = '0;
        for (int i = 0; i < NCH; i++) div_ratio[i*DW +: DW] = DW'(ratio_r[i]);
    end

    typedef struct packed {
        logic [NCH-1:0] clk_e;
        logic [NCH-1:0] act_e;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: whether running, active ratio, and position within the current period.
    int m_act [NCH];
    int m_R   [NCH];
    int m_ph  [NCH];

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    function automatic int clampr(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    // High during the first half of the period, rounded up: 2*pos < R.
    function automatic logic exp_clk(input int c);
        return (m_act[c] != 0) && (2 * m_ph[c] < m_R[c]);
    endfunction

    task automatic model_edge();
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_act[c] = 0; m_ph[c] = 0; m_R[c] = 2;
            end else if (m_act[c] == 0) begin
                if (en[c]) begin
                    m_act[c] = 1; m_R[c] = clampr(ratio_r[c]); m_ph[c] = 0;
                end
            end else if (m_ph[c] == m_R[c] - 1) begin
                m_ph[c] = 0;
                if (en[c]) m_R[c] = clampr(ratio_r[c]);
                else m_act[c] = 0;
            end else begin
                m_ph[c] = m_ph[c] + 1;
            end
            e.clk_e[c] = exp_clk(c);
            e.act_e[c] = (m_act[c] != 0);
        end
        sb_q.push_back(e);
    endtask

    // One clk cycle: model follows the rising edge, inputs may change 2 time units after the falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_ph(input int c, input int ph, input string name);
        int k;
        k = 0;
        while (!(m_act[c] != 0 && m_ph[c] == ph) && k < 200) begin
            step(1);
            k++;
        end
        if (k >= 200) begin
            n_chk++;
            $display("FAIL %s: timeout waiting ch%0d phase %0d", name, c, ph);
        end
    endtask

    // Monitor: compares the DUT outputs against the queued expectation on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("clkout", 32'(clkout), 32'(e.clk_e));
                check("div_active", 32'(div_active), 32'(e.act_e));
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        en  = '0;
        for (int i = 0; i < NCH; i++) begin
            ratio_r[i] = 0; m_act[i] = 0; m_R[i] = 2; m_ph[i] = 0;
        end
        #1;
        check("r_act_reset", 32'(dut.r_act_q[1]), 32'd2);
        step(3);
        rst = 1'b0;
        step(2);

        // Even ratio on ch0, odd ratio on ch1, then clamped ratios 0 and 1.
        ratio_r[0] = 4; en[0] = 1'b1;
        step(12);
        ratio_r[1] = 5; en[1] = 1'b1;
        step(15);
        ratio_r[1] = 0;
        step(12);
        ratio_r[1] = 1;
        step(10);

        // Ratio change 4 -> 6 written at position 1 of a period.
        wait_ph(0, 1, "ratio_chg");
        ratio_r[0] = 6;
        step(16);

        // Stop at position 0 of ratio 8, then re-enable exactly on a boundary.
        ratio_r[2] = 8; en[2] = 1'b1;
        step(1);
        en[2] = 1'b0;
        step(12);
        en[2] = 1'b1;
        step(1);
        wait_ph(2, 3, "stop_mid");
        en[2] = 1'b0;
        wait_ph(2, 7, "boundary");
        en[2] = 1'b1;
        step(20);

        // Independence: ratios 2/3/7/15 with staggered enables and toggles on ch1.
        en = '0;
        step(20);
        ratio_r[0] = 2; ratio_r[1] = 3; ratio_r[2] = 7; ratio_r[3] = 15;
        en[0] = 1'b1; step(3);
        en[1] = 1'b1; step(5);
        en[2] = 1'b1; step(7);
        en[3] = 1'b1; step(40);
        en[1] = 1'b0; step(9);
        en[1] = 1'b1; step(30);

        // Asynchronous reset while ch0 clkout is high.
        k = 0;
        while (!exp_clk(0) && k < 50) begin
            step(1);
            k++;
        end
        if (k >= 50) begin
            n_chk++;
            $display("FAIL rst_wait: ch0 never high");
        end
        check("pre_rst_clkout0", 32'(clkout[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_clkout", 32'(clkout), 32'd0);
        check("async_rst_active", 32'(div_active), 32'd0);
        check("async_rst_r_act", 32'(dut.r_act_q[3]), 32'd2);
        check("async_rst_cnt", 32'(dut.cnt_q[3]), 32'd0);
        #1;
        step(2);
        rst = 1'b0;
        step(20);

        // Randomised run with occasional ratio changes, enable toggles and reset pulses.
        repeat (800) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 9) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 7) == 0) ratio_r[c] = $urandom_range(0, 15);
            end
            rst = ($urandom_range(0, 249) == 0);
            step(1);
        end
        rst = 1'b0;
        step(3);

        k = 0;
        while (sb_q.size() > 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
